mem_access_unit: RTL and testbench

Memory-stage load/store sequencer of the 16-bit MIPS CPU, sitting between the execute stage and the 64-word, negedge-clocked data memory. Accepts one load or store request per handshake, drives the memory's address/read/write/data strobes for exactly one cycle, captures the read word on the following rising edge, and presents a completion record (data, destination register, fault flag) to writeback under valid/ready backpressure. Out-of-range addresses are trapped here and never reach the memory.

---
 rtl/mem_access_unit.sv | 128 ++++++++++++
 tb/tb_mem_access_unit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store sequencer.
// One request per handshake, one-cycle strobe, record to writeback.
module mem_access_unit #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  input  logic [3:0]        req_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic              wb_is_load,
  output logic [3:0]        wb_rd,
  output logic [15:0]       wb_data,
  output logic              wb_fault,
  output logic [7:0]        fault_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_xfer;
  logic                w_fault;
  logic                r_we;
  logic                r_fault;
  logic [ADDR_W-1:0]   r_addr;
  logic [15:0]         r_wdata;
  logic [3:0]          r_rd;
  logic                r_wb_is_load;
  logic [3:0]          r_wb_rd;
  logic [15:0]         r_wb_data;
  logic                r_wb_fault;
  logic [7:0]          r_fault_count;

  assign w_fault = (req_addr >= ADDR_W'(DEPTH));
  assign w_xfer  = req_valid & req_ready;

  // Next state and strobes; strobes are decoded from state so reset drops them at once.
  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    wb_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = S_ACCESS;
      end
      S_ACCESS: begin
        mem_read  = ~r_we & ~r_fault;
        mem_write = r_we & ~r_fault;
        w_next    = S_RESP;
      end
      S_RESP: begin
        wb_valid  = 1'b1;
        req_ready = wb_ready;
        if (wb_ready) w_next = req_valid ? S_ACCESS : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Latch the accepted request; the fault decision is made once here.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_we    <= 1'b0;
      r_fault <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rd    <= '0;
    end else if (w_xfer) begin
      r_we    <= req_we;
      r_fault <= w_fault;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_rd    <= req_rd;
    end
  end

  // Build the completion record at the end of the access cycle.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_wb_is_load  <= 1'b0;
      r_wb_rd       <= '0;
      r_wb_data     <= '0;
      r_wb_fault    <= 1'b0;
      r_fault_count <= '0;
    end else if (r_state == S_ACCESS) begin
      r_wb_is_load <= ~r_we;
      r_wb_rd      <= r_rd;
      r_wb_fault   <= r_fault;
      r_wb_data    <= (~r_we & ~r_fault) ? mem_rdata : 16'h0000;
      if (r_fault && r_fault_count != 8'hFF)
        r_fault_count <= r_fault_count + 8'd1;
    end
  end

  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign wb_is_load  = r_wb_is_load;
  assign wb_rd       = r_wb_rd;
  assign wb_data     = r_wb_data;
  assign wb_fault    = r_wb_fault;
  assign fault_count = r_fault_count;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed bench with negedge data memory,
// transaction-level reference model and literal spot checks.
module tb_mem_access_unit;

  logic        Clk;
  logic        Rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [3:0]  req_rd;
  logic [15:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_is_load;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data;
  logic        wb_fault;
  logic [7:0]  fault_count;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int acc_cyc = 0;
  int n_rd   = 0;
  int n_wr   = 0;

  logic [15:0] dmem [64];
  logic [15:0] model_mem [64];

  mem_access_unit #(.DEPTH(64), .ADDR_W(16)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_is_load(wb_is_load), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_fault(wb_fault),
    .fault_count(fault_count)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc++;

  // Data memory: acts on the falling edge.
  always @(negedge Clk) begin
    if (mem_write) dmem[mem_addr[5:0]] <= mem_wdata;
    if (mem_read)  mem_rdata <= dmem[mem_addr[5:0]];
  end

  always @(negedge Clk) begin
    if (mem_read)  n_rd++;
    if (mem_write) n_wr++;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  // Reference model: tracks the in-flight request and the held record.
  logic        m_acc, m_rec_v, m_we, m_flt;
  logic [15:0] m_addr, m_wdata;
  logic [3:0]  m_rd;
  logic        e_is_load, e_fault;
  logic [3:0]  e_rd;
  logic [15:0] e_data;
  int          m_fc;
  logic        take;

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      m_acc = 0; m_rec_v = 0; m_we = 0;
      m_addr = 0; m_wdata = 0; m_rd = 0;
      e_is_load = 0; e_fault = 0; e_rd = 0;
      e_data = 0; m_fc = 0;
    end else begin
      take = req_valid && !m_acc && (!m_rec_v || wb_ready);
      if (m_acc) begin
        m_flt     = (m_addr > 16'd63);
        e_is_load = !m_we;
        e_rd      = m_rd;
        e_fault   = m_flt;
        e_data    = 0;
        if (!m_flt && !m_we) e_data = model_mem[m_addr[5:0]];
        if (!m_flt && m_we) model_mem[m_addr[5:0]] = m_wdata;
        if (m_flt) m_fc = (m_fc == 255) ? 255 : m_fc + 1;
        m_rec_v = 1;
        m_acc   = 0;
      end else if (m_rec_v && wb_ready) begin
        m_rec_v = 0;
      end
      if (take) begin
        m_acc   = 1;
        m_we    = req_we;
        m_addr  = req_addr;
        m_wdata = req_wdata;
        m_rd    = req_rd;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge Clk) begin
    if (cyc > 0) begin
      chk("req_ready", 32'(req_ready),
          32'(!m_acc && (!m_rec_v || wb_ready)));
      chk("mem_read", 32'(mem_read),
          32'(m_acc && !m_we && m_addr < 16'd64));
      chk("mem_write", 32'(mem_write),
          32'(m_acc && m_we && m_addr < 16'd64));
      chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
      chk("wb_valid", 32'(wb_valid), 32'(m_rec_v));
      chk("wb_is_load", 32'(wb_is_load), 32'(e_is_load));
      chk("wb_rd", 32'(wb_rd), 32'(e_rd));
      chk("wb_data", 32'(wb_data), 32'(e_data));
      chk("wb_fault", 32'(wb_fault), 32'(e_fault));
      chk("fault_count", 32'(fault_count), 32'(m_fc));
    end
  end

  // Present a request after the next edge and hold it until accepted.
  task automatic send(input logic we, input logic [15:0] a,
                      input logic [15:0] d, input logic [3:0] rd);
    bit ok;
    ok = 0;
    @(posedge Clk); #2;
    req_valid = 1; req_we = we; req_addr = a;
    req_wdata = d; req_rd = rd;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      if (req_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge Clk); #2;
    acc_cyc = cyc;
    req_valid = 0;
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_rec(input string nm, input logic il,
                            input logic [3:0] rd,
                            input logic [15:0] d,
                            input logic f);
    bit seen;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (wb_valid) begin
        seen = 1;
        break;
      end
    end
    chk({nm, "_valid"}, 32'(seen), 32'd1);
    chk({nm, "_latency"}, 32'(cyc - acc_cyc), 32'd1);
    chk({nm, "_is_load"}, 32'(wb_is_load), 32'(il));
    chk({nm, "_rd"}, 32'(wb_rd), 32'(rd));
    chk({nm, "_data"}, 32'(wb_data), 32'(d));
    chk({nm, "_fault"}, 32'(wb_fault), 32'(f));
  endtask

  int r0, w0;
  logic rr [4];

  initial begin
    for (int i = 0; i < 64; i++) begin
      dmem[i]      = 16'(i * 7);
      model_mem[i] = 16'(i * 7);
    end
    dmem[1] = 16'h0002; model_mem[1] = 16'h0002;
    dmem[2] = 16'h0003; model_mem[2] = 16'h0003;
    dmem[3] = 16'h0006; model_mem[3] = 16'h0006;
    mem_rdata = 0;
    req_valid = 0; req_we = 0; req_addr = 0;
    req_wdata = 0; req_rd = 0; wb_ready = 1;
    Rst_n = 1;
    #1 Rst_n = 0;

    // Reset values.
    @(negedge Clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_fault_count", 32'(fault_count), 32'd0);
    @(posedge Clk); #2 Rst_n = 1;

    // Load addr 1.
    r0 = n_rd;
    send(0, 16'd1, 16'h0, 4'd5);
    expect_rec("ld1", 1, 4'd5, 16'h0002, 0);
    #1 chk("ld1_pulses", 32'(n_rd - r0), 32'd1);

    // Store 0xBEEF to 10, load 10 back-to-back.
    @(posedge Clk); #2;
    w0 = n_wr;
    req_valid = 1; req_we = 1; req_addr = 16'd10;
    req_wdata = 16'hBEEF; req_rd = 4'd1;
    @(negedge Clk); rr[0] = req_ready;
    @(posedge Clk); #2;
    req_we = 0; req_rd = 4'd6; req_wdata = 16'h0;
    @(negedge Clk); rr[1] = req_ready;
    chk("st10_write", 32'(mem_write), 32'd1);
    @(negedge Clk); rr[2] = req_ready;
    chk("st10_data", 32'(wb_data), 32'd0);
    chk("st10_is_load", 32'(wb_is_load), 32'd0);
    @(posedge Clk); #2 req_valid = 0;
    @(negedge Clk); rr[3] = req_ready;
    chk("ld10_read", 32'(mem_read), 32'd1);
    @(negedge Clk);
    chk("ld10_valid", 32'(wb_valid), 32'd1);
    chk("ld10_data", 32'(wb_data), 32'hBEEF);
    chk("ld10_rd", 32'(wb_rd), 32'd6);
    chk("rdy_pattern", 32'({rr[0], rr[1], rr[2], rr[3]}), 32'b1010);
    #1 chk("st10_pulses", 32'(n_wr - w0), 32'd1);

    // Faulted load and store.
    r0 = n_rd; w0 = n_wr;
    send(0, 16'd64, 16'h0, 4'd7);
    expect_rec("ld64", 1, 4'd7, 16'h0, 1);
    send(1, 16'hFFFF, 16'h5555, 4'd8);
    expect_rec("stFFFF", 0, 4'd8, 16'h0, 1);
    chk("fault_count2", 32'(fault_count), 32'd2);
    #1 chk("fault_pulses", 32'((n_rd - r0) + (n_wr - w0)), 32'd0);

    // Backpressure on a load of addr 3.
    @(posedge Clk); #2 wb_ready = 0;
    r0 = n_rd;
    send(0, 16'd3, 16'h0, 4'd9);
    req_valid = 1; req_we = 0; req_addr = 16'd1; req_rd = 4'd2;
    @(negedge Clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk("bp_valid", 32'(wb_valid), 32'd1);
      chk("bp_data", 32'(wb_data), 32'h0006);
      chk("bp_ready", 32'(req_ready), 32'd0);
    end
    #1 chk("bp_pulses", 32'(n_rd - r0), 32'd1);
    @(posedge Clk); #2 wb_ready = 1;
    @(negedge Clk);
    chk("bp_release_ready", 32'(req_ready), 32'd1);
    @(posedge Clk); #2;
    acc_cyc = cyc;
    req_valid = 0;
    expect_rec("ld1b", 1, 4'd2, 16'h0002, 0);

    // Saturation of the fault counter.
    for (int i = 0; i < 256; i++)
      send(0, 16'h0100, 16'h0, 4'd3);
    @(negedge Clk);
    chk("fault_sat", 32'(fault_count), 32'd255);

    // Reset during the access cycle of a store.
    send(1, 16'd2, 16'h1234, 4'd0);
    #1 Rst_n = 0;
    @(negedge Clk);
    chk("mid_rst_write", 32'(mem_write), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_valid", 32'(wb_valid), 32'd0);
    chk("mid_rst_fc", 32'(fault_count), 32'd0);
    chk("mid_rst_addr", 32'(mem_addr), 32'd0);
    @(posedge Clk); #2 Rst_n = 1;
    @(negedge Clk);
    #1;
    chk("mem2_kept", 32'(dmem[2]), 32'h0003);
    chk("mem10_beef", 32'(dmem[10]), 32'hBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
